// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial add controller: controller state
// encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell
// Combinational 1-bit full adder built from gate primitives (zero delay).
// This is the single cell time-shared by serial_add_ctrl.
// Ports:
//   a, b, ci  operand bits and carry-in
//   sum, co   sum bit and carry-out
module fa_cell (
  input  logic      a,
  input  logic      b,
  input  logic      ci,
  output wire logic sum,
  output wire logic co
);

  wire w_p;
  wire w_g;
  wire w_t;

  xor g_p   (w_p, a, b);
  xor g_sum (sum, w_p, ci);
  and g_g   (w_g, a, b);
  and g_t   (w_t, w_p, ci);
  or  g_co  (co, w_g, w_t);

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per clock,
// LSB first, through a single fa_cell with a registered carry between bits.
// A start accepted while ready=1 captures the operands; done pulses for one
// cycle when {co_out,sum_out} holds a_in + b_in + ci_in.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   start           request, only sampled while ready=1
//   sub             (SERIAL_ADD_SUB_EN only) 1 = compute a_in - b_in
//   a_in, b_in      operands, captured on the accepted start
//   ci_in           carry-in, captured on the accepted start
//   ready           idle and able to accept start
//   busy            serial add in progress
//   done            one-cycle result-valid pulse
//   sum_out, co_out registered result, held until the next done
//
// Optional feature macro: SERIAL_ADD_SUB_EN adds the sub port. With sub=1 the
// B register loads ~b_in and the carry flop loads 1 (two's complement
// subtract); co_out=1 then means no borrow.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready=1, waiting for start
// RUN   | one operand bit per clock through fa_cell, WIDTH clocks total
// DONE  | done=1 for one cycle, then back to IDLE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             co_out
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Only WIDTH-1 sum bits need storing: the last bit comes straight from the
  // cell on the final edge and goes directly into sum_out.
  logic [WIDTH-2:0] r_sum_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_co_out;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load = sub ? ~b_in : b_in;
  assign w_c_load = sub | ci_in;
`else
  assign w_b_load = b_in;
  assign w_c_load = ci_in;
`endif

  fa_cell u_fa (
    .a   (r_a_sr[0]),
    .b   (r_b_sr[0]),
    .ci  (r_carry),
    .sum (w_s),
    .co  (w_c)
  );

  assign w_sum_next = {w_s, r_sum_sr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_sum_sr  <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_sum_out <= '0;
      r_co_out  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a_in;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_sum_sr <= w_sum_next[WIDTH-1:1];
          r_carry  <= w_c;
          if (r_cnt == LAST_BIT) begin
            // Counter stays at WIDTH-1 here; it is cleared on next acceptance.
            r_sum_out <= w_sum_next;
            r_co_out  <= w_c;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign busy    = (r_state == RUN);
  assign done    = r_done;
  assign sum_out = r_sum_out;
  assign co_out  = r_co_out;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in  = '0;
  logic [7:0] b_in  = '0;
  logic       ci_in = 1'b0;
  logic       ready, busy, done;
  logic [7:0] sum_out;
  logic       co_out;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       ci2 = 1'b0;
  logic       ready2, busy2, done2;
  logic [1:0] sum2;
  logic       co2;

`ifdef SERIAL_ADD_SUB_EN
  logic sub  = 1'b0;
  logic sub2 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub     (sub),
`endif
    .a_in    (a_in),
    .b_in    (b_in),
    .ci_in   (ci_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .co_out  (co_out)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
`ifdef SERIAL_ADD_SUB_EN
    .sub     (sub2),
`endif
    .a_in    (a2),
    .b_in    (b2),
    .ci_in   (ci2),
    .ready   (ready2),
    .busy    (busy2),
    .done    (done2),
    .sum_out (sum2),
    .co_out  (co2)
  );

  // Issue one operation on the 8-bit DUT from an idle point (#1 after an edge)
  // and return the result seen on the done cycle, the latency in cycles from
  // the accepting edge, and whether sum_out moved before done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output int lat,
                        output bit early);
    logic [7:0] held;
    held  = sum_out;
    early = 1'b0;
    lat   = -1;
    s     = '0;
    co    = 1'b0;
    a_in  = a;
    b_in  = b;
    ci_in = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    ci_in = 1'($urandom);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        s   = sum_out;
        co  = co_out;
        break;
      end
      if (sum_out !== held) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if ({co_out, sum_out} !== 9'h000) begin bad++; $display("FAIL reset_result got=%h exp=000", {co_out, sum_out}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] va [3] = '{8'h3C, 8'hFF, 8'hFF};
    logic [7:0] vb [3] = '{8'h5A, 8'h01, 8'hFF};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'h96, 8'h00, 8'hFF};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] s;
    logic co;
    int lat;
    bit early;
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], vc[k], s, co, lat, early);
      total++; if (lat !== 8) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=8", k, lat); end
      total++; if (s !== es[k]) begin bad++; $display("FAIL dir%0d_sum got=%h exp=%h", k, s, es[k]); end
      total++; if (co !== ec[k]) begin bad++; $display("FAIL dir%0d_co got=%0b exp=%0b", k, co, ec[k]); end
      total++; if (early) begin bad++; $display("FAIL dir%0d_early_result got=1 exp=0", k); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_width got=%0b exp=0", k, done); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL dir%0d_ready_return got=%0b exp=1", k, ready); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, s;
    logic c, co;
    logic [8:0] exp;
    int lat;
    bit early;
    for (int k = 0; k < 25; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(c);
      run_op(a, b, c, s, co, lat, early);
      total++; if ({co, s} !== exp) begin bad++; $display("FAIL rand%0d_result a=%h b=%h ci=%0b got=%h exp=%h", k, a, b, c, {co, s}, exp); end
      total++; if (lat !== 8) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=8", k, lat); end
      total++; if (early) begin bad++; $display("FAIL rand%0d_early_result got=1 exp=0", k); end
      @(posedge clk); #1;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  // start is held high and operands change every cycle; the operation
  // accepted from step i must complete at step i+9 and the next acceptance
  // follows 10 steps later.
  task automatic test_back_to_back();
    logic [16:0] ops [40];
    logic [8:0] exp;
    logic exp_done;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin
        exp_done = (i >= 9) && ((i - 9) % 10 == 0);
        total++; if (done !== exp_done) begin bad++; $display("FAIL b2b_done step=%0d got=%0b exp=%0b", i, done, exp_done); end
        if (exp_done) begin
          exp = 9'(ops[i-9][16:9]) + 9'(ops[i-9][8:1]) + 9'(ops[i-9][0]);
          total++; if ({co_out, sum_out} !== exp) begin bad++; $display("FAIL b2b_result step=%0d got=%h exp=%h", i, {co_out, sum_out}, exp); end
        end
      end
      ops[i] = 17'($urandom);
      a_in  = ops[i][16:9];
      b_in  = ops[i][8:1];
      ci_in = ops[i][0];
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s;
    logic co;
    int lat;
    bit early;
    bit saw_done;
    run_op(8'h3C, 8'h5A, 1'b0, s, co, lat, early);
    @(posedge clk); #1;
    a_in = 8'hFF; b_in = 8'hFF; ci_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b exp=1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%0b exp=0", done); end
    total++; if ({co_out, sum_out} !== 9'h000) begin bad++; $display("FAIL midrst_result got=%h exp=000", {co_out, sum_out}); end
    rst = 1'b0; start = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL midrst_no_done got=1 exp=0"); end
    run_op(8'h01, 8'h01, 1'b0, s, co, lat, early);
    total++; if ({co, s} !== 9'h002) begin bad++; $display("FAIL midrst_after got=%h exp=002", {co, s}); end
    total++; if (lat !== 8) begin bad++; $display("FAIL midrst_after_latency got=%0d exp=8", lat); end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    logic [7:0] s;
    logic co;
    int lat;
    bit early;
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, s, co, lat, early);
    total++; if ({co, s} !== 9'h10F) begin bad++; $display("FAIL sub_10_01 got=%h exp=10f", {co, s}); end
    @(posedge clk); #1;
    run_op(8'h01, 8'h02, 1'b1, s, co, lat, early);
    total++; if ({co, s} !== 9'h0FF) begin bad++; $display("FAIL sub_01_02 got=%h exp=0ff", {co, s}); end
    @(posedge clk); #1;
    sub = 1'b0;
    run_op(8'h3C, 8'h5A, 1'b0, s, co, lat, early);
    total++; if ({co, s} !== 9'h096) begin bad++; $display("FAIL sub0_regress got=%h exp=096", {co, s}); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_width2();
    logic [2:0] exp;
    int lat;
    for (int v = 31; v >= 0; v--) begin
      a2  = 2'(v >> 3);
      b2  = 2'(v >> 1);
      ci2 = 1'(v);
      exp = 3'(a2) + 3'(b2) + 3'(ci2);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk); #1;
        if (done2) begin lat = i; break; end
      end
      total++; if (lat !== 2) begin bad++; $display("FAIL w2_latency v=%0d got=%0d exp=2", v, lat); end
      total++; if ({co2, sum2} !== exp) begin bad++; $display("FAIL w2_result v=%0d got=%b exp=%b", v, {co2, sum2}, exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_width2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add controller that time-shares one gate-level 1-bit full-adder cell to add two WIDTH-bit operands.
- Processes one bit per clock, LSB first, with a registered carry between bits.
- Uses a ready/start handshake on the input side and a one-cycle done pulse on the output side.
- Sits between a requester and the 1-bit adder datapath, trading latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a_in  input  WIDTH  operand A; captured on the accepted start.
- b_in  input  WIDTH  operand B; captured on the accepted start.
- ci_in  input  1  carry-in; captured on the accepted start.
- ready  output  1  idle and able to accept start (decoded from state).
- busy  output  1  operation in progress (state RUN).
- done  output  1  one-cycle pulse; result valid.
- sum_out  output  WIDTH  registered result; held until the next done.
- co_out  output  1  registered carry-out; held with sum_out.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum_out=0, co_out=0, carry flop=0, counter=0, shift registers=0.
- FSM states:
  - IDLE: ready=1. If start=1 at an edge, capture a_in, b_in and ci_in (into the carry flop), clear the counter, go to RUN. If start=0, stay.
  - RUN: busy=1, ready=0. Each edge:
    - fa_cell computes s,c from a_sr[0], b_sr[0], carry.
    - a_sr and b_sr shift right.
    - s shifts into sum_sr MSB.
    - carry<=c; counter++.
    - On the edge where counter==WIDTH-1, go to DONE and load sum_out<=final sum_sr value and co_out<=c.
  - DONE: done=1 for exactly this one cycle; next edge go to IDLE unconditionally.
- Latency:
  - Start sampled at edge E → done high during the cycle after edge E+WIDTH.
  - ready returns after edge E+WIDTH+1.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while ready=0 is ignored (not queued).
- Input changes after capture do not affect the result.
- sum_out/co_out change only on the RUN→DONE edge; no intermediate values are visible.
- Arithmetic: {co_out,sum_out} = a_in + b_in + ci_in, modulo 2^(WIDTH+1).
- Reset mid-operation: rst overrides all transitions, including a simultaneous start.
  - The next cycle is IDLE with reset values.
  - No done is produced; the partial result is discarded.
- Counter wrap does not occur: it is cleared on acceptance and never exceeds WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands.
  - If sub=1: b_sr loads ~b_in, the carry flop loads 1, and ci_in is ignored. Result = a_in − b_in; co_out=1 means no borrow.
  - If sub=0: behaviour is identical to the base block.
- When undefined: no sub port; add only.

Decomposition:
- Package serial_add_pkg holds:
  - state typedef/constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default WIDTH constant.
- One sub-module, fa_cell: combinational gate-level full adder built from xor/and/or primitives with zero delay. Ports a, b, ci, sum, co.
- The controller instantiates exactly one fa_cell.

Test Plan:
- Reset, then a=8'h3C, b=8'h5A, ci=0 → sum_out=8'h96, co_out=0; done exactly 8 cycles after the start edge, one cycle wide; ready=1 one cycle later.
- a=8'hFF, b=8'h01, ci=0 → 8'h00, co=1. Then a=8'hFF, b=8'hFF, ci=1 → 8'hFF, co=1.
- start held high continuously with operands changed during RUN:
  - ops complete every 10 cycles;
  - results match the operands captured at acceptance;
  - no extra done pulses.
- rst asserted for one cycle during RUN (counter=4):
  - next cycle IDLE, ready=1, sum_out=0, co_out=0, no done;
  - the following 8'h01+8'h01 gives 8'h02 (no stale carry).
- SERIAL_ADD_SUB_EN defined:
  - sub=1, 8'h10−8'h01 → 8'h0F, co=1.
  - sub=1, 8'h01−8'h02 → 8'hFF, co=0.
  - sub=0 regression of the first scenario passes.
- WIDTH=2: a=2'b11, b=2'b01, ci=1 → sum_out=2'b01, co_out=1; done 2 cycles after the start edge.
